sweep_sequencer: RTL and testbench
==================================

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 Parameter: ADDR_W, 4, vertex index width; must match the vertex/predecessor address width.
REQ-002 Parameter: TIMEOUT, 4096, maximum cycles allowed per engine phase; legal range 2..65535.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  host request to begin one arbitrage sweep.
REQ-006 Port: src  in  ADDR_W  source vertex, sampled with an accepted start.
REQ-007 Port: host_we  in  1  host adjacency-matrix write enable (raw).
REQ-008 Port: host_we_gated  out  1  host write enable forwarded to adjacency memory.
REQ-009 Port: src_q  out  ADDR_W  latched source vertex driven to both engines.
REQ-010 Port: bf_start  out  1  one-cycle kick to the Bellman engine (drives its reset).
REQ-011 Port: bf_done  in  1  Bellman engine completion level.
REQ-012 Port: cd_start  out  1  one-cycle kick to the cycle-detect engine.
REQ-013 Port: cd_done  in  1  cycle-detect completion level.
REQ-014 Port: cd_found  in  1  negative cycle found; valid while cd_done=1.
REQ-015 Port: owner  out  2  memory port owner select: 00 host, 01 Bellman, 10 cycle-detect; 11 never driven.
REQ-016 Port: busy  out  1  sweep in progress.
REQ-017 Port: done  out  1  last sweep finished (level).
REQ-018 Port: found  out  1  result of last sweep.
REQ-019 Port: timeout_err  out  1  last sweep aborted by phase timeout.
REQ-020 Port: run_count  out  16  number of finished sweeps, modulo 2^16.

Function
REQ-021 FSM states SHALL be IDLE, BF_KICK, BF_RUN, CD_KICK, CD_RUN, FINISH; state is registered, and all outputs except host_we_gated are decoded from registers.
REQ-022 IDLE: start=1 SHALL latch src into src_q, clear done/found/timeout_err, and move to BF_KICK on the same edge.
REQ-023 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-024 BF_KICK: bf_start=1 for exactly this one cycle; owner=01; phase timer cleared; next state BF_RUN unconditionally.
REQ-025 bf_done sampled in BF_KICK SHALL be ignored; it is stale from the prior run.
REQ-026 BF_RUN: bf_done=1 moves to CD_KICK; otherwise timer increments; timer==TIMEOUT-1 without bf_done sets timeout_err=1 and moves to FINISH.
REQ-027 CD_KICK: cd_start=1 for one cycle; owner=10; timer cleared; next state CD_RUN; cd_done in this cycle is ignored.
REQ-028 CD_RUN: cd_done=1 loads found<=cd_found and moves to FINISH; timeout is handled identically to REQ-026.
REQ-029 If done and the timeout limit occur on the same edge, done SHALL take precedence (no timeout_err).
REQ-030 FINISH: lasts one cycle; done<=1; run_count<=run_count+1 (0xFFFF wraps to 0x0000); owner<=00; next state IDLE.
REQ-031 done, found, and timeout_err SHALL hold until the next accepted start.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 owner SHALL be 01 in BF_KICK/BF_RUN, 10 in CD_KICK/CD_RUN, and 00 otherwise.
REQ-034 host_we_gated SHALL equal host_we in IDLE and be 0 elsewhere; host writes outside IDLE are dropped.
REQ-035 The phase timer SHALL be $clog2(TIMEOUT) bits wide and SHALL never wrap within a phase.
REQ-036 Latency: bf_start is high in the cycle immediately after the edge that samples start.

Reset
REQ-037 reset=0 SHALL immediately force state=IDLE, owner=00, src_q=0, and all 1-bit outputs=0 except host_we_gated, which follows host_we; it SHALL also force run_count=0 and timer=0.
REQ-038 reset asserted mid-sweep SHALL abort without pulsing bf_start or cd_start; no run is counted.

Verification
REQ-039 Normal sweep: src=3, start pulse; bf_done 10 cycles after bf_start; cd_done with cd_found=1 5 cycles after cd_start.
  -> bf_start and cd_start each high for one cycle; owner sequence 01 then 10 then 00; src_q=3; done=1; found=1; run_count=1.
REQ-040 Timeout: TIMEOUT=16, bf_done held 0.
  -> timeout_err=1 and FINISH entered 16 cycles after BF_RUN entry; cd_start never pulses; done=1; found=0.
REQ-041 Host gating: host_we=1 in IDLE then in BF_RUN.
  -> host_we_gated=1 in IDLE, 0 in BF_RUN.
REQ-042 Repeated start: start held high for 30 cycles.
  -> exactly one bf_start per sweep; a new sweep begins only after FINISH returns to IDLE.
REQ-043 Stale done: bf_done held 1 from before start.
  -> ignored in BF_KICK; CD_KICK entered one cycle after BF_RUN entry.
REQ-044 Reset mid CD_RUN.
  -> outputs take REQ-037 values immediately and asynchronously; run_count=0; a following start sweeps normally.

Source files
------------

// File: rtl/sweep_sequencer_if.sv
// Host and engine handshake bundle for the sweep sequencer.
// The slave modport is the sequencer's view; master is the host/engine side.
interface sweep_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic              host_we;
  logic              host_we_gated;
  logic [ADDR_W-1:0] src_q;
  logic              bf_start;
  logic              bf_done;
  logic              cd_start;
  logic              cd_done;
  logic              cd_found;
  logic [1:0]        owner;
  logic              busy;
  logic              done;
  logic              found;
  logic              timeout_err;
  logic [15:0]       run_count;

  modport slave (
    input  start, src, host_we, bf_done, cd_done, cd_found,
    output host_we_gated, src_q, bf_start, cd_start, owner, busy,
           done, found, timeout_err, run_count
  );

  modport master (
    output start, src, host_we, bf_done, cd_done, cd_found,
    input  host_we_gated, src_q, bf_start, cd_start, owner, busy,
           done, found, timeout_err, run_count
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Sequences one arbitrage sweep: Bellman phase, then cycle-detect phase, each bounded by a phase timer.
// Kicks/owner/busy decode straight from the state register; only host_we_gated is combinational from an input.
module sweep_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  sweep_sequencer_if.slave   bus
);
  localparam int                TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, BF_KICK, BF_RUN, CD_KICK, CD_RUN, FINISH
  } state_t;

  state_t              r_state,       w_state_nxt;
  logic [TMR_W-1:0]    r_timer,       w_timer_nxt;
  logic [ADDR_W-1:0]   r_src_q,       w_src_q_nxt;
  logic                r_done,        w_done_nxt;
  logic                r_found,       w_found_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic [15:0]         r_run_count,   w_run_count_nxt;
  logic [1:0]          w_owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_src_q       <= '0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_run_count   <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_src_q       <= w_src_q_nxt;
      r_done        <= w_done_nxt;
      r_found       <= w_found_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_run_count   <= w_run_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_src_q_nxt       = r_src_q;
    w_done_nxt        = r_done;
    w_found_nxt       = r_found;
    w_timeout_err_nxt = r_timeout_err;
    w_run_count_nxt   = r_run_count;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_src_q_nxt       = bus.src;
          w_done_nxt        = 1'b0;
          w_found_nxt       = 1'b0;
          w_timeout_err_nxt = 1'b0;
          w_state_nxt       = BF_KICK;
        end
      end
      // Done levels seen during a kick cycle are left over from the previous run.
      BF_KICK: begin
        w_timer_nxt = '0;
        w_state_nxt = BF_RUN;
      end
      BF_RUN: begin
        if (bus.bf_done) begin
          w_state_nxt = CD_KICK;
        end else if (r_timer == TMR_LAST) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = FINISH;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      CD_KICK: begin
        w_timer_nxt = '0;
        w_state_nxt = CD_RUN;
      end
      CD_RUN: begin
        if (bus.cd_done) begin
          w_found_nxt = bus.cd_found;
          w_state_nxt = FINISH;
        end else if (r_timer == TMR_LAST) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = FINISH;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      FINISH: begin
        w_done_nxt      = 1'b1;
        w_run_count_nxt = r_run_count + 16'd1;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_owner = 2'b00;
    case (r_state)
      BF_KICK, BF_RUN: w_owner = 2'b01;
      CD_KICK, CD_RUN: w_owner = 2'b10;
      default:         w_owner = 2'b00;
    endcase
  end

  assign bus.owner         = w_owner;
  assign bus.bf_start      = (r_state == BF_KICK);
  assign bus.cd_start      = (r_state == CD_KICK);
  assign bus.busy          = (r_state != IDLE);
  assign bus.host_we_gated = bus.host_we & (r_state == IDLE);
  assign bus.src_q         = r_src_q;
  assign bus.done          = r_done;
  assign bus.found         = r_found;
  assign bus.timeout_err   = r_timeout_err;
  assign bus.run_count     = r_run_count;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: stimulus queues expected kick/done events,
// a negedge monitor pops and compares them, including cycle gaps between events.
module tb_sweep_sequencer;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sweep_sequencer_if #(.ADDR_W(AW)) sif();

  sweep_sequencer #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  typedef struct {
    int kind;   // 0 bf_start, 1 cd_start, 2 done rising
    int gap;    // cycles since previous event, -1 = don't care
    int owner;
    int src_q;
    int found;
    int terr;
    int rc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int gap, input int owner, input int src,
                      input int found, input int terr, input int rc);
    exp_t e;
    e.kind = kind; e.gap = gap; e.owner = owner; e.src_q = src;
    e.found = found; e.terr = terr; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic check_evt(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
      return;
    end
    e = sb.pop_front();
    chk("evt_kind", kind, e.kind);
    if (e.gap >= 0) chk("evt_gap", cyc - last_cyc, e.gap);
    last_cyc = cyc;
    chk("evt_owner", sif.owner, e.owner);
    chk("evt_src_q", sif.src_q, e.src_q);
    chk("evt_busy", sif.busy, (kind == 2) ? 0 : 1);
    if (kind == 2) begin
      chk("evt_found", sif.found, e.found);
      chk("evt_timeout_err", sif.timeout_err, e.terr);
      chk("evt_run_count", sif.run_count, e.rc);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        done_q = 1'b0;
      end else begin
        if (sif.bf_start === 1'b1) check_evt(0);
        if (sif.cd_start === 1'b1) check_evt(1);
        if (sif.done === 1'b1 && done_q !== 1'b1) check_evt(2);
        done_q = sif.done;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int max);
    int k = 0;
    while (sif.done !== 1'b1 && k < max) begin
      tick(1);
      k++;
    end
    chk(nm, sif.done, 1);
  endtask

  task automatic drain(input string nm);
    tick(2);
    chk(nm, sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_owner"}, sif.owner, 0);
    chk({nm, "_busy"}, sif.busy, 0);
    chk({nm, "_bf_start"}, sif.bf_start, 0);
    chk({nm, "_cd_start"}, sif.cd_start, 0);
    chk({nm, "_done"}, sif.done, 0);
    chk({nm, "_found"}, sif.found, 0);
    chk({nm, "_timeout_err"}, sif.timeout_err, 0);
    chk({nm, "_src_q"}, sif.src_q, 0);
    chk({nm, "_run_count"}, sif.run_count, 0);
    chk({nm, "_host_we_gated"}, sif.host_we_gated, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    reset        = 1'b0;
    sif.start    = 1'b0;
    sif.src      = '0;
    sif.host_we  = 1'b0;
    sif.bf_done  = 1'b0;
    sif.cd_done  = 1'b0;
    sif.cd_found = 1'b0;
    #2;
    sif.host_we = 1'b1;
    #1;
    check_reset_vals("reset");
    sif.host_we = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);

    // Normal sweep with host gating
    sif.host_we = 1'b1;
    #1;
    chk("host_gate_idle", sif.host_we_gated, 1);
    push(0, -1, 1, 3, 0, 0, 0);
    push(1, 11, 2, 3, 0, 0, 0);
    push(2, 7, 0, 3, 1, 0, 1);
    sif.src   = 4'd3;
    sif.start = 1'b1;
    tick(1);
    sif.start = 1'b0;
    sif.src   = 4'd0;
    tick(1);
    chk("host_gate_bf_run", sif.host_we_gated, 0);
    chk("owner_bf_run", sif.owner, 1);
    sif.host_we = 1'b0;
    tick(9);
    sif.bf_done = 1'b1;
    tick(6);
    sif.bf_done  = 1'b0;
    sif.cd_done  = 1'b1;
    sif.cd_found = 1'b1;
    wait_done("normal_done", 10);
    sif.cd_done  = 1'b0;
    sif.cd_found = 1'b0;
    drain("normal_drain");

    // Bellman phase timeout
    push(0, -1, 1, 5, 0, 0, 0);
    push(2, 18, 0, 5, 0, 1, 2);
    sif.src   = 4'd5;
    sif.start = 1'b1;
    tick(1);
    sif.start = 1'b0;
    wait_done("timeout_done", 30);
    drain("timeout_drain");

    // Stale done levels from before start
    sif.bf_done  = 1'b1;
    sif.cd_done  = 1'b1;
    sif.cd_found = 1'b0;
    push(0, -1, 1, 7, 0, 0, 0);
    push(1, 2, 2, 7, 0, 0, 0);
    push(2, 3, 0, 7, 0, 0, 3);
    sif.src   = 4'd7;
    sif.start = 1'b1;
    tick(1);
    sif.start = 1'b0;
    wait_done("stale_done", 20);
    drain("stale_drain");

    // Start held high: back-to-back sweeps, each 6 cycles long
    sif.cd_found = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(0, (k == 0) ? -1 : 1, 1, 10, 0, 0, 0);
      push(1, 2, 2, 10, 0, 0, 0);
      push(2, 3, 0, 10, 1, 0, 4 + k);
    end
    sif.src   = 4'd10;
    sif.start = 1'b1;
    tick(30);
    sif.start    = 1'b0;
    sif.bf_done  = 1'b0;
    sif.cd_done  = 1'b0;
    sif.cd_found = 1'b0;
    drain("repeat_drain");
    chk("repeat_run_count", sif.run_count, 8);

    // Asynchronous reset in the middle of CD_RUN
    sif.bf_done = 1'b1;
    push(0, -1, 1, 12, 0, 0, 0);
    push(1, 2, 2, 12, 0, 0, 0);
    sif.src   = 4'd12;
    sif.start = 1'b1;
    tick(1);
    sif.start = 1'b0;
    tick(4);
    chk("pre_reset_owner_cd", sif.owner, 2);
    #2;
    sif.host_we = 1'b1;
    reset       = 1'b0;
    #1;
    check_reset_vals("midreset");
    chk("midreset_sb_empty", sb.size(), 0);
    sif.bf_done = 1'b0;
    tick(2);
    reset       = 1'b1;
    sif.host_we = 1'b0;
    tick(1);

    // Fresh sweep after reset counts from zero
    sif.bf_done  = 1'b1;
    sif.cd_done  = 1'b1;
    sif.cd_found = 1'b1;
    push(0, -1, 1, 9, 0, 0, 0);
    push(1, 2, 2, 9, 0, 0, 0);
    push(2, 3, 0, 9, 1, 0, 1);
    sif.src   = 4'd9;
    sif.start = 1'b1;
    tick(1);
    sif.start = 1'b0;
    wait_done("post_reset_done", 20);
    sif.bf_done  = 1'b0;
    sif.cd_done  = 1'b0;
    sif.cd_found = 1'b0;
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
